// File: rtl/edge_detect_pkg.sv
// Shared types and limits for the edge detector array: edge-mode encoding,
// counter width and parameter bounds.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  localparam int CNT_W      = 8;
  localparam int MIN_CH     = 1;
  localparam int MAX_CH     = 32;
  localparam int MIN_SYNC   = 2;
  localparam int MAX_SYNC   = 4;
  localparam int MIN_FILTER = 1;
  localparam int MAX_FILTER = 255;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic mode_match(input logic [1:0] m, input logic rise, input logic fall);
    return (rise && m[0]) || (fall && m[1]);
  endfunction

endpackage

// File: rtl/edge_filter_chan.sv
// One channel: synchronizer chain, optional glitch filter, filtered level and
// one-cycle rise/fall strobes that coincide with the level change.
module edge_filter_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic                   accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

`ifdef EDGE_DETECT_ARRAY_FILTER_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The FILTER_CYCLES-th consecutive mismatching cycle accepts the new value.
  assign accept = (sync != level) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((sync == level) || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign accept = (sync != level);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (accept) begin
        level <= sync;
      end
      rise_pulse <= accept & sync;
      fall_pulse <= accept & ~sync;
    end
  end

endmodule

// File: rtl/edge_detect_array.sv
// Array of independent edge-detect channels with sticky per-channel event flags
// and a registered interrupt. Glitch filter is built only with EDGE_DETECT_ARRAY_FILTER_EN.
module edge_detect_array
  import edge_detect_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     sig_in,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     event_clr,
  output logic [NUM_CH-1:0]     level_out,
  output logic [NUM_CH-1:0]     rise_pulse,
  output logic [NUM_CH-1:0]     fall_pulse,
  output logic [NUM_CH-1:0]     event_flag,
  output logic                  irq
);

  if (NUM_CH < MIN_CH || NUM_CH > MAX_CH ||
      SYNC_STAGES < MIN_SYNC || SYNC_STAGES > MAX_SYNC ||
      FILTER_CYCLES < MIN_FILTER || FILTER_CYCLES > MAX_FILTER) begin : g_bad_cfg
    $error("edge_detect_array: parameter out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    edge_filter_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in[i]),
      .level     (level_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  logic [NUM_CH-1:0] flag_set;

  // Mode is looked at while the strobe is high, so later mode changes leave flags alone.
  always_comb begin
    flag_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      flag_set[i] = mode_match(mode[2*i +: 2], rise_pulse[i], fall_pulse[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_flag <= '0;
      irq        <= 1'b0;
    end else begin
      event_flag <= flag_set | (event_flag & ~event_clr);
      irq        <= |event_flag;
    end
  end

endmodule

// File: doc/edge_detect_array.md
EDGE_DETECT_ARRAY -- requirements
Module: edge_detect_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per channel (2..4).
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, consecutive stable cycles required before a level change is accepted (1..255).
REQ-004 SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port sig_in, input, NUM_CH, asynchronous signals to monitor.
REQ-007 SHALL have port mode, input, 2*NUM_CH, per-channel edge select; bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port event_clr, input, NUM_CH, per-channel clear of sticky event flag, one-cycle pulse.
REQ-009 SHALL have port level_out, output, NUM_CH, filtered level per channel.
REQ-010 SHALL have port rise_pulse, output, NUM_CH, one-cycle strobe on accepted rising edge, independent of mode.
REQ-011 SHALL have port fall_pulse, output, NUM_CH, one-cycle strobe on accepted falling edge, independent of mode.
REQ-012 SHALL have port event_flag, output, NUM_CH, sticky flag set by edges enabled by mode.
REQ-013 SHALL have port irq, output, 1, registered OR of all event_flag bits.

Function
REQ-014 SHALL pass each sig_in bit through SYNC_STAGES flops to form sync[i]; no logic between stages.
REQ-015 SHALL keep a per-channel stability counter: sync==level -> counter cleared; sync!=level -> counter increments; on the FILTER_CYCLES-th consecutive mismatching cycle, level updates to sync and counter clears.
REQ-016 SHALL restart the count on any glitch shorter than FILTER_CYCLES cycles; level_out does not change.
REQ-017 SHALL assert rise_pulse[i] (fall_pulse[i]) in exactly the cycle level_out[i] first shows 1 (0), for one cycle.
REQ-018 SHALL give latency from first clk edge sampling a new stable sig_in value to the pulse of SYNC_STAGES+FILTER_CYCLES cycles.
REQ-019 SHALL set event_flag[i] on the cycle after an accepted edge matching mode[i]; mode 00 never sets it.
REQ-020 SHALL clear event_flag[i] on the cycle after event_clr[i]=1; if set and clear coincide, set wins.
REQ-021 SHALL sample mode at edge acceptance time; changing mode does not alter existing flags.
REQ-022 SHALL drive irq one cycle after any event_flag becomes 1, deasserted one cycle after all flags are 0.
REQ-023 SHALL keep all channels fully independent; simultaneous edges on all channels are all captured.

Reset
REQ-024 SHALL on rst_n low asynchronously clear sync flops, counters, level_out, rise_pulse, fall_pulse, event_flag and irq to 0.
REQ-025 SHALL treat a channel held high through reset release as a rising edge after SYNC_STAGES+FILTER_CYCLES cycles.
REQ-026 SHALL, on reset asserted mid-filter, discard the partial count and any pending edge.

Configuration
REQ-027 SHALL compile the glitch filter only when macro EDGE_DETECT_ARRAY_FILTER_EN is defined.
REQ-028 SHALL, without EDGE_DETECT_ARRAY_FILTER_EN, omit counters, ignore FILTER_CYCLES, and register level <= sync every cycle (latency SYNC_STAGES+1).

Structure
REQ-029 SHALL place the mode encoding typedef (OFF/RISE/FALL/BOTH), and width constants for the counter and parameter limits in shared package edge_detect_pkg.
REQ-030 SHALL implement one channel (synchronizer, filter, level, pulses) in sub-module edge_filter_chan, instantiated NUM_CH times; flags and irq in the top level.

Verification
REQ-031 SHALL check: NUM_CH=8, SYNC_STAGES=2, FILTER_CYCLES=4, sig_in[0] 0->1 held -> rise_pulse[0] high exactly 6 cycles later for one cycle, level_out[0]=1.
REQ-032 SHALL check: 3-cycle high glitch on sig_in[1] -> no pulse, level_out[1] stays 0.
REQ-033 SHALL check: mode[5:4]=10, ch2 rise then fall -> rise_pulse and fall_pulse both strobe; event_flag[2] set only after fall; irq one cycle later.
REQ-034 SHALL check: event_clr[3] asserted in the same cycle an enabled edge sets flag 3 -> event_flag[3] remains 1.
REQ-035 SHALL check: all 8 inputs rise together with mode=all 11 -> all 8 rise_pulse bits high same cycle, event_flag=8'hFF, then event_clr=8'hFF -> flags 0, irq drops next cycle.
REQ-036 SHALL check: rst_n pulsed low mid-filter -> all outputs 0 immediately; build without EDGE_DETECT_ARRAY_FILTER_EN -> pulse latency 3 cycles, 1-cycle glitch propagates.
